// File: rtl/uc_pkg.sv
// uc_pkg: opcodes, ALU codes and step encodings shared by the control unit.
package uc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;
    localparam logic [1:0] ULA_AND = 2'b10;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

endpackage

// File: rtl/decode_onehot.sv
// decode_onehot: binary index to one-hot vector of width N.
module decode_onehot #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx_i,
    output logic [N-1:0] onehot_o
);

    assign onehot_o = {{(N-1){1'b0}}, 1'b1} << idx_i;

endmodule

// File: rtl/unidade_controle_param.sv
// unidade_controle_param: multi-cycle control unit with its own T0-T3 step counter.
// Define UC_MVNZ_EN to execute opcode 100 as mvnz; otherwise it is illegal.
module unidade_controle_param
    import uc_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int RIDX_W = $clog2(NREG),
    parameter int IW     = 3 + 2*RIDX_W
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IW-1:0]   Instrucao,
    input  logic            Gnz,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic [1:0]      Ulaop,
    output logic            Done,
    output logic            Ilegal,
    output logic [1:0]      Tstep
);

`ifdef UC_MVNZ_EN
    localparam bit MVNZ_EN = 1'b1;
`else
    localparam bit MVNZ_EN = 1'b0;
`endif

    step_t           step_q, step_d;
    logic [2:0]      opcode;
    logic [NREG-1:0] rx_oh, ry_oh;

    assign opcode = Instrucao[IW-1 -: 3];
    assign Tstep  = step_q;

    decode_onehot #(.N(NREG), .W(RIDX_W)) u_dec_rx (
        .idx_i    (Instrucao[2*RIDX_W-1:RIDX_W]),
        .onehot_o (rx_oh)
    );

    decode_onehot #(.N(NREG), .W(RIDX_W)) u_dec_ry (
        .idx_i    (Instrucao[RIDX_W-1:0]),
        .onehot_o (ry_oh)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) step_q <= T0;
        else         step_q <= step_d;
    end

    always_comb begin
        step_d = step_q;
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Ulaop  = ULA_ADD;
        Done   = 1'b0;
        Ilegal = 1'b0;
        case (step_q)
            T0: begin
                // IRin is gated so nothing loads while reset is held
                IRin   = Run & Resetn;
                step_d = Run ? T1 : T0;
            end
            T1: begin
                step_d = T0;
                Done   = 1'b1;
                case (opcode)
                    OP_MV: begin
                        Rin  = rx_oh;
                        Rout = ry_oh;
                    end
                    OP_MVI: begin
                        Rin    = rx_oh;
                        DINout = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        Rout   = rx_oh;
                        Ain    = 1'b1;
                        Done   = 1'b0;
                        step_d = T2;
                    end
                    OP_MVNZ: begin
                        // when G is zero Rx is rewritten with itself
                        Rin    = MVNZ_EN ? rx_oh : '0;
                        Rout   = MVNZ_EN ? (Gnz ? ry_oh : rx_oh) : '0;
                        Ilegal = !MVNZ_EN;
                    end
                    default: Ilegal = 1'b1;
                endcase
            end
            T2: begin
                step_d = T3;
                Rout   = ry_oh;
                Gin    = 1'b1;
                Ulaop  = (opcode == OP_SUB) ? ULA_SUB : (opcode == OP_AND) ? ULA_AND : ULA_ADD;
            end
            T3: begin
                step_d = T0;
                Gout   = 1'b1;
                Rin    = rx_oh;
                Done   = 1'b1;
            end
            default: step_d = T0;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_param.sv
// tb_unidade_controle_param: vector table, random model check and reset/NREG=16 sequences.
module tb_unidade_controle_param;

`ifdef UC_MVNZ_EN
    localparam bit MVNZ = 1'b1;
`else
    localparam bit MVNZ = 1'b0;
`endif

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic [1:0] ulaop;
        logic       done;
        logic       ilegal;
        logic [1:0] tstep;
    } out_t;

    typedef struct {
        logic [8:0] ins;
        logic       run;
        logic       gnz;
        out_t       exp;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Resetn, Run, Gnz;
    logic [8:0]  Instrucao;
    logic        IRin, Ain, Gin, Gout, DINout, Done, Ilegal;
    logic [7:0]  Rin, Rout;
    logic [1:0]  Ulaop, Tstep;

    logic [10:0] Instrucao16 = 11'b000_1111_1001;
    logic        IRin16, Ain16, Gin16, Gout16, DINout16, Done16, Ilegal16;
    logic [15:0] Rin16, Rout16;
    logic [1:0]  Ulaop16, Tstep16;

    int vectors = 0;
    int errors  = 0;

    always #5 Clock = ~Clock;

    unidade_controle_param dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao), .Gnz(Gnz),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .DINout(DINout), .Ulaop(Ulaop), .Done(Done), .Ilegal(Ilegal), .Tstep(Tstep)
    );

    unidade_controle_param #(.NREG(16)) dut16 (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao16), .Gnz(Gnz),
        .IRin(IRin16), .Rin(Rin16), .Rout(Rout16), .Ain(Ain16), .Gin(Gin16), .Gout(Gout16),
        .DINout(DINout16), .Ulaop(Ulaop16), .Done(Done16), .Ilegal(Ilegal16), .Tstep(Tstep16)
    );

    function automatic out_t o(logic irin, logic [7:0] rin, logic [7:0] rout, logic ain,
                               logic gin, logic gout, logic din, logic [1:0] ula,
                               logic done, logic il, logic [1:0] ts);
        return {irin, rin, rout, ain, gin, gout, din, ula, done, il, ts};
    endfunction

    // Reference: expected outputs at step k (0 = fetch) of the instruction ins.
    function automatic out_t model(logic [8:0] ins, int k, logic run, logic gnz);
        out_t       e = '0;
        int         op = int'(ins[8:6]);
        logic [7:0] x = 8'(1) << ins[5:3];
        logic [7:0] y = 8'(1) << ins[2:0];
        bit         alu = (op == 2) || (op == 3) || (op == 5);
        bit         legal = (op <= 1) || alu || (MVNZ && op == 4);
        e.tstep = 2'(k);
        if (k == 0) e.irin = run;
        else if (!legal) begin
            e.done = 1'b1;
            e.ilegal = 1'b1;
        end else if (!alu) begin
            e.done = 1'b1;
            e.rin = x;
            e.dinout = (op == 1);
            e.rout = (op == 0) ? y : (op == 4) ? (gnz ? y : x) : 8'h00;
        end else if (k == 1) begin
            e.rout = x;
            e.ain = 1'b1;
        end else if (k == 2) begin
            e.rout = y;
            e.gin = 1'b1;
            e.ulaop = (op == 3) ? 2'd1 : (op == 5) ? 2'd2 : 2'd0;
        end else begin
            e.gout = 1'b1;
            e.rin = x;
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic int next_k(logic [8:0] ins, int k, logic run);
        int len = (ins[8:6] == 3'd2 || ins[8:6] == 3'd3 || ins[8:6] == 3'd5) ? 4 : 2;
        return (k == 0) ? (run ? 1 : 0) : (k == len - 1) ? 0 : k + 1;
    endfunction

    task automatic chk(input string name, input out_t exp);
        out_t act = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, Done, Ilegal, Tstep};
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    vec_t tbl[24];

    initial begin
        int k;
        tbl[0]  = '{9'o130, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[1]  = '{9'o130, 1'b0, 1'b0, o(0, 8'h08, 8'h00, 0, 0, 0, 1, 2'd0, 1, 0, 2'd1)};
        tbl[2]  = '{9'o130, 1'b0, 1'b0, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[3]  = '{9'o312, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[4]  = '{9'o312, 1'b0, 1'b0, o(0, 8'h00, 8'h02, 1, 0, 0, 0, 2'd0, 0, 0, 2'd1)};
        tbl[5]  = '{9'o312, 1'b0, 1'b0, o(0, 8'h00, 8'h04, 0, 1, 0, 0, 2'd1, 0, 0, 2'd2)};
        tbl[6]  = '{9'o312, 1'b0, 1'b0, o(0, 8'h02, 8'h00, 0, 0, 1, 0, 2'd0, 1, 0, 2'd3)};
        tbl[7]  = '{9'o700, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[8]  = '{9'o700, 1'b0, 1'b0, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1, 2'd1)};
        tbl[9]  = '{9'o056, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[10] = '{9'o056, 1'b1, 1'b0, o(0, 8'h20, 8'h40, 0, 0, 0, 0, 2'd0, 1, 0, 2'd1)};
        tbl[11] = '{9'o211, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[12] = '{9'o211, 1'b1, 1'b0, o(0, 8'h00, 8'h02, 1, 0, 0, 0, 2'd0, 0, 0, 2'd1)};
        tbl[13] = '{9'o211, 1'b0, 1'b0, o(0, 8'h00, 8'h02, 0, 1, 0, 0, 2'd0, 0, 0, 2'd2)};
        tbl[14] = '{9'o211, 1'b0, 1'b0, o(0, 8'h02, 8'h00, 0, 0, 1, 0, 2'd0, 1, 0, 2'd3)};
        tbl[15] = '{9'o570, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[16] = '{9'o570, 1'b1, 1'b0, o(0, 8'h00, 8'h80, 1, 0, 0, 0, 2'd0, 0, 0, 2'd1)};
        tbl[17] = '{9'o570, 1'b1, 1'b0, o(0, 8'h00, 8'h01, 0, 1, 0, 0, 2'd2, 0, 0, 2'd2)};
        tbl[18] = '{9'o570, 1'b0, 1'b0, o(0, 8'h80, 8'h00, 0, 0, 1, 0, 2'd0, 1, 0, 2'd3)};
        tbl[19] = '{9'o445, 1'b1, 1'b1, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[20] = '{9'o445, 1'b0, 1'b1, MVNZ ? o(0, 8'h10, 8'h20, 0, 0, 0, 0, 2'd0, 1, 0, 2'd1)
                                              : o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1, 2'd1)};
        tbl[21] = '{9'o445, 1'b1, 1'b0, o(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};
        tbl[22] = '{9'o445, 1'b0, 1'b0, MVNZ ? o(0, 8'h10, 8'h10, 0, 0, 0, 0, 2'd0, 1, 0, 2'd1)
                                              : o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1, 2'd1)};
        tbl[23] = '{9'o056, 1'b0, 1'b0, o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0)};

        Resetn = 1'b0;
        Run = 1'b1;
        Gnz = 1'b0;
        Instrucao = 9'o130;
        cyc();
        chk("reset", o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0));
        Resetn = 1'b1;
        Run = 1'b0;

        for (int i = 0; i < 24; i++) begin
            Instrucao = tbl[i].ins;
            Run = tbl[i].run;
            Gnz = tbl[i].gnz;
            #1 chk($sformatf("vec%0d", i), tbl[i].exp);
            cyc();
        end

        k = 0;
        for (int n = 0; n < 400; n++) begin
            if (k == 0) Instrucao = 9'($urandom);
            Run = ($urandom_range(0, 3) != 0);
            Gnz = 1'($urandom);
            #1 chk($sformatf("rand%0d", n), model(Instrucao, k, Run, Gnz));
            k = next_k(Instrucao, k, Run);
            cyc();
        end

        Resetn = 1'b0;
        Run = 1'b0;
        cyc();
        Resetn = 1'b1;
        Run = 1'b1;
        Instrucao = 9'o312;
        #1 chk_v("n16_fetch", {30'd0, IRin16, Tstep16 == 2'd0}, 32'd3);
        cyc();
        Run = 1'b0;
        #1 chk_v("n16_rin", {16'd0, Rin16}, 32'h8000);
        chk_v("n16_rout", {16'd0, Rout16}, 32'h0200);
        chk_v("n16_done", {29'd0, Done16, Ilegal16, DINout16}, 32'd4);
        cyc();
        #1 chk("sub_t2", o(0, 8'h00, 8'h04, 0, 1, 0, 0, 2'd1, 0, 0, 2'd2));
        Resetn = 1'b0;
        Run = 1'b1;
        #1 chk("rst_mid", o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0));
        cyc();
        chk("rst_hold", o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0));
        Resetn = 1'b1;
        Run = 1'b0;
        #1 chk("post_rst", o(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0));
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
